// File: rtl/decision_tx_pkg.sv
// Shared types and helpers for the decision TX framer.
// Frame lengths, ASCII constants, state enum, decision bundle.
package decision_tx_pkg;

  localparam int FRAME_LEN_BIN   = 7;
  localparam int FRAME_LEN_ASCII = 13;

  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  typedef struct packed {
    logic [7:0]  typ;
    logic [31:0] data;
  } decision_t;

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] frame_chk(
    input logic [7:0]  t,
    input logic [31:0] d
  );
    return t ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

endpackage

// File: rtl/decision_fifo.sv
// Synchronous FIFO of decision_t entries.
// Head entry is read straight from the storage registers.
module decision_fifo
  import decision_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  decision_t                    i_data,
  input  logic                         i_pop,
  output decision_t                    o_data,
  output logic [$clog2(FIFO_DEPTH):0]  o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  decision_t       r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_count;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd];
  assign o_count   = r_count;

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= i_data;
  end

  // Pointers and occupancy; push+pop nets to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/decision_tx_framer.sv
// Serialises queued decisions into a framed byte stream.
// DECISION_TX_ASCII_EN selects 13-byte hex text frames.
module decision_tx_framer
  import decision_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         DROP_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_type,
  input  logic [31:0]       in_data,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

`ifdef DECISION_TX_ASCII_EN
  localparam int FRAME_LEN = FRAME_LEN_ASCII;
`else
  localparam int FRAME_LEN = FRAME_LEN_BIN;
`endif
  localparam logic [3:0] LAST = 4'(FRAME_LEN - 1);

  state_t                      r_state;
  state_t                      w_state_nx;
  decision_t                   r_frame;
  decision_t                   w_frame_nx;
  logic [3:0]                  r_idx;
  logic [3:0]                  w_idx_nx;
  logic [7:0]                  r_out_byte;
  logic [7:0]                  w_byte_nx;
  logic                        r_out_valid;
  logic                        w_valid_nx;
  logic [DROP_W-1:0]           r_drop;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  decision_t                   w_head;
  decision_t                   w_in;

  function automatic logic [7:0] frame_byte(
    input decision_t  f,
    input logic [3:0] idx
  );
`ifdef DECISION_TX_ASCII_EN
    logic [31:0] sh;
    sh = f.data >> {4'd10 - idx, 2'b00};
    case (idx)
      4'd0:    return nib2hex(f.typ[7:4]);
      4'd1:    return nib2hex(f.typ[3:0]);
      4'd2:    return COLON;
      4'd11:   return CR;
      4'd12:   return LF;
      default: return nib2hex(sh[3:0]);
    endcase
`else
    case (idx)
      4'd0:    return SYNC_BYTE;
      4'd1:    return f.typ;
      4'd2:    return f.data[31:24];
      4'd3:    return f.data[23:16];
      4'd4:    return f.data[15:8];
      4'd5:    return f.data[7:0];
      default: return frame_chk(f.typ, f.data);
    endcase
`endif
  endfunction

  assign w_in      = '{typ: in_type, data: in_data};
  assign in_ready  = !w_full;
  assign out_byte  = r_out_byte;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == SEND) || (w_count != '0);
  assign drop_cnt  = r_drop;

  decision_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next frame/byte/state; reload on the last handshake keeps zero gap.
  always_comb begin
    w_state_nx = r_state;
    w_frame_nx = r_frame;
    w_idx_nx   = r_idx;
    w_byte_nx  = r_out_byte;
    w_valid_nx = r_out_valid;
    w_pop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_frame_nx = w_head;
          w_idx_nx   = '0;
          w_state_nx = SEND;
        end
      end
      SEND: begin
        if (!r_out_valid) begin
          w_byte_nx  = frame_byte(r_frame, r_idx);
          w_valid_nx = 1'b1;
        end else if (out_ready) begin
          if (r_idx == LAST) begin
            if (!w_empty) begin
              w_pop      = 1'b1;
              w_frame_nx = w_head;
              w_idx_nx   = '0;
              w_byte_nx  = frame_byte(w_head, 4'd0);
            end else begin
              w_state_nx = IDLE;
              w_valid_nx = 1'b0;
              w_byte_nx  = '0;
            end
          end else begin
            w_idx_nx  = r_idx + 4'd1;
            w_byte_nx = frame_byte(r_frame, r_idx + 4'd1);
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State, frame register and registered byte outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_frame     <= '0;
      r_idx       <= '0;
      r_out_byte  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_frame     <= w_frame_nx;
      r_idx       <= w_idx_nx;
      r_out_byte  <= w_byte_nx;
      r_out_valid <= w_valid_nx;
    end
  end

  // Saturating count of decisions refused while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (in_valid && w_full && (r_drop != '1)) begin
      r_drop <= r_drop + 1'b1;
    end
  end

endmodule

// File: tb/tb_decision_tx_framer.sv
// Testbench for decision_tx_framer (binary or ASCII build).
// Byte stream checked against a scoreboard queue.
module tb_decision_tx_framer;

`ifdef DECISION_TX_ASCII_EN
  localparam int FLEN = 13;
`else
  localparam int FLEN = 7;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_type;
  logic [31:0] in_data;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] drop_cnt;

  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  logic [7:0]  sb[$];

  decision_tx_framer #(
    .FIFO_DEPTH(4),
    .SYNC_BYTE (8'hA5),
    .DROP_W    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_data   (in_data),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic void exp_frame(input logic [7:0] t, input logic [31:0] d);
`ifdef DECISION_TX_ASCII_EN
    string s;
    s = $sformatf("%02X:%08X", t, d);
    for (int i = 0; i < 11; i++) sb.push_back(s[i]);
    sb.push_back(8'h0D);
    sb.push_back(8'h0A);
`else
    sb.push_back(8'hA5);
    sb.push_back(t);
    sb.push_back(d[31:24]);
    sb.push_back(d[23:16]);
    sb.push_back(d[15:8]);
    sb.push_back(d[7:0]);
    sb.push_back(t ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
`endif
  endfunction

  // Output monitor: scoreboard compare on handshake, hold check on stall.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_byte;
    logic [7:0] exp;
    prev_stall = 1'b0;
    prev_byte  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (out_valid !== 1'b1 || out_byte !== prev_byte) begin
            errors++;
            $display("FAIL hold: valid=%b byte=%02h, required valid=1 byte=%02h",
                     out_valid, out_byte, prev_byte);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          hs_cnt++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got %02h, required none", out_byte);
          end else begin
            exp = sb.pop_front();
            if (out_byte !== exp) begin
              errors++;
              $display("FAIL byte: got %02h, required %02h", out_byte, exp);
            end
          end
        end
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev_byte  = out_byte;
      end
    end
  end

  task automatic push_dec(input logic [7:0] t, input logic [31:0] d, input bit acc);
    in_valid = 1'b1;
    in_type  = t;
    in_data  = d;
    checks++;
    if (in_ready !== acc) begin
      errors++;
      $display("FAIL in_ready: got %b, required %b", in_ready, acc);
    end
    if (acc) exp_frame(t, d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes left, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_type   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    checks += 5;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %b, required 0", out_valid);
    end
    if (out_byte !== 8'h00) begin
      errors++; $display("FAIL rst_byte: got %02h, required 00", out_byte);
    end
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b, required 0", busy);
    end
    if (drop_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_drop: got %0d, required 0", drop_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [7:0]  t;
    logic [31:0] d;
    int          nv;
`ifdef DECISION_TX_ASCII_EN
    logic [7:0] lit [13] = '{8'h32, 8'h42, 8'h3A, 8'h44, 8'h45, 8'h41, 8'h44,
                             8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    t = 8'h2B;
    d = 32'hDEADBEEF;
`else
    logic [7:0] lit [7] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    t = 8'h01;
    d = 32'h12345678;
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_type   = t;
    in_data   = d;
    for (int i = 0; i < FLEN; i++) sb.push_back(lit[i]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_n: got valid=%b, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_n1: got valid=%b, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_byte !== lit[0]) begin
      errors++;
      $display("FAIL lat_n2: got valid=%b byte=%02h, required 1 %02h",
               out_valid, out_byte, lit[0]);
    end
    nv = 1;
    @(negedge clk);
    while (out_valid === 1'b1 && nv < 40) begin
      nv++;
      @(negedge clk);
    end
    checks += 2;
    if (nv != FLEN) begin
      errors++; $display("FAIL single_len: got %0d bytes, required %0d", nv, FLEN);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy: got %b, required 0", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n = 0;
    out_ready = 1'b1;
    push_dec(8'h01, 32'h12345678, 1'b1);
    while (sb.size() != 0 && n < 200) begin
      out_ready = pat[n % 4];
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      push_dec(8'h10 + 8'(i), $urandom, i < 5);
    checks += 2;
    if (drop_cnt !== 16'd1) begin
      errors++; $display("FAIL ovf_drop: got %0d, required 1", drop_cnt);
    end
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ovf_in_ready: got %b, required 0", in_ready);
    end
    out_ready = 1'b1;
    wait_drain();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ovf_after: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int nv = 0;
    out_ready = 1'b1;
    push_dec(8'hC3, 32'hA5A55A5A, 1'b1);
    push_dec(8'h7E, 32'h0BADF00D, 1'b1);
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    while (out_valid === 1'b1 && nv < 60) begin
      nv++;
      @(negedge clk);
    end
    checks++;
    if (nv != 2 * FLEN) begin
      errors++;
      $display("FAIL b2b_run: got %0d consecutive, required %0d", nv, 2 * FLEN);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_reset_midframe();
    int start;
    int n = 0;
    int seen = 0;
    out_ready = 1'b1;
    start = hs_cnt;
    push_dec(8'h5A, 32'hCAFEF00D, 1'b1);
    while (hs_cnt < start + 3 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks += 3;
    if (n >= 50) begin
      errors++; $display("FAIL mid_timeout: got %0d handshakes, required 3", hs_cnt - start);
    end
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_valid: got %b, required 0", out_valid);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mid_busy: got %b, required 0", busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks += 3;
    if (seen != 0) begin
      errors++; $display("FAIL mid_resume: got %0d valid cycles, required 0", seen);
    end
    if (drop_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_drop: got %0d, required 0", drop_cnt);
    end
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL leftover: %0d bytes, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decision_tx_framer.md
Name: decision_tx_framer

Overview:
Sits between the logic→TX pipeline stage and uart_tx. Accepts (type, 32-bit data) decisions into a small FIFO. Serialises each decision into a framed byte stream over a valid/ready byte interface, so the full decision reaches the UART instead of only 8 bits.

Parameters:
FIFO_DEPTH, 4, decision entries buffered (power of 2, ≥2)
SYNC_BYTE, 8'hA5, first byte of every binary frame
DROP_W, 16, width of saturating drop counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  decision present
in_ready  output  1  FIFO not full
in_type  input  8  decision type
in_data  input  32  decision data
out_byte  output  8  byte to UART
out_valid  output  1  out_byte valid
out_ready  input  1  UART can accept byte
busy  output  1  frame in progress or FIFO non-empty
drop_cnt  output  DROP_W  decisions lost to full FIFO

Behaviour:
- Reset: all outputs 0 except in_ready=1; FIFO emptied; FSM→IDLE; drop_cnt=0. Takes effect immediately mid-frame: out_valid drops asynchronously, and the partial frame is never resumed.
- in_ready = (count != FIFO_DEPTH), combinational from registered count. No same-cycle bypass when full.
- Push occurs on in_valid & in_ready. A push with in_valid & !in_ready is discarded and drop_cnt += 1, saturating at all-ones.
- Simultaneous push and pop adjusts count by net 0.
- Binary frame, 7 bytes, MSB first: SYNC_BYTE, type, d[31:24], d[23:16], d[15:8], d[7:0], CHK. CHK is the XOR of type and the four data bytes (SYNC excluded).
- FSM states: IDLE, SEND. A byte index 0..FRAME_LEN-1 is held in a frame shift/register.
- IDLE: if FIFO non-empty, pop and latch the entry into the frame register; next state SEND with index 0; out_valid=1 from the next cycle.
- SEND: out_valid=1. On out_ready, index += 1. On the last-byte handshake:
  - FIFO non-empty: pop and load in the same edge; SYNC is presented next cycle (zero gap).
  - Otherwise go to IDLE; out_valid=0.
- out_byte and out_valid are registered. While out_valid & !out_ready, out_byte is held stable.
- Latency: decision accepted at edge N with FSM idle and FIFO empty → first byte valid after edge N+2.
- Effective capacity is FIFO_DEPTH+1 decisions (one in the frame register).
- busy = (state==SEND) | (count!=0).

Optional Feature:
Macro DECISION_TX_ASCII_EN.
- Defined: frame is 13 printable bytes:
  - 2 uppercase hex chars of type
  - ':' (0x3A)
  - 8 uppercase hex chars of data, MSB nibble first
  - CR (0x0D), LF (0x0A)
  - No SYNC and no CHK.
- Undefined: the 7-byte binary frame above.
- FSM, handshake, and latency rules are identical in both modes; only FRAME_LEN and byte generation differ.

Decomposition:
- Package decision_tx_pkg holds:
  - FRAME_LEN_BIN=7 and FRAME_LEN_ASCII=13
  - ASCII constants (COLON, CR, LF)
  - state enum typedef {IDLE, SEND}
  - function nib2hex(4-bit)→8-bit ASCII
  - function frame_chk(type, data)
  - packed struct decision_t {type[7:0], data[31:0]}
- Sub-module decision_fifo: synchronous FIFO of decision_t with push/pop/count/full/empty, registered output, FIFO_DEPTH parameter.

Test Plan:
- Single binary frame: type=0x01, data=0x12345678, out_ready=1 → bytes A5 01 12 34 56 78 09 on 7 consecutive cycles; first byte 2 cycles after accept; busy drops after last byte.
- Backpressure: same decision with out_ready toggling 1,0,0,1,… → each byte is held stable while valid & !ready; the sequence is unchanged with no duplicate or skipped bytes.
- Overflow: out_ready=0, push 6 consecutive decisions → 5 accepted; in_ready=0 after the 5th; 6th dropped; drop_cnt=1. Releasing out_ready then yields 5 complete frames in order.
- Back-to-back: two decisions queued, out_ready=1 → 14 consecutive valid bytes, second SYNC directly after first CHK.
- Reset mid-frame: rst_n low after 3rd byte handshake → out_valid=0 the same cycle. After release, with no new input, no bytes appear, drop_cnt=0 and in_ready=1.
- DECISION_TX_ASCII_EN defined: type=0x2B, data=0xDEADBEEF → 32 42 3A 44 45 41 44 42 45 45 46 0D 0A.
